// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for multi-cycle
// writers (load, mul/div). It stalls ID until each source operand can be
// forwarded, and stretches control-redirect flushes over FLUSH_CYCLES cycles.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush cycle
// counters. Without it, both counter ports are tied to zero.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_W        = 5,
  parameter int MAX_LAT      = 7,
  parameter int ECALL_REG    = 17,
  parameter int FLUSH_CYCLES = 1,
  localparam int LAT_W       = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_ecall,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [LAT_W-1:0] ex_lat,
  input  logic             redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             control_op,
  output logic             if_flush,
  output logic             id_flush,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
);

  localparam int IDX_N = 1 << REG_W;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [FC_W-1:0]                flush_q, flush_d;
  logic [IDX_N-1:0]               pend;
  logic [LAT_W-1:0]               lat_eff;
  logic                           issue, hazard, flushing, stall;

  // Every real writer in EX records a result; latencies above MAX_LAT are clamped.
  assign issue   = ex_valid && ex_reg_write && (ex_rd != '0);
  assign lat_eff = (ex_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : ex_lat;

  // Next-state timers: the youngest writer overwrites, all others count down to 0.
  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue && ex_rd == REG_W'(r))
        cnt_d[r] = (lat_eff == '0) ? '0 : lat_eff - LAT_W'(1);
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      else
        cnt_d[r] = '0;
    end
  end

  // Pending view, padded to the full index space so any rs value is safe to look up.
  always_comb begin
    pend = '0;
    for (int r = 1; r < NUM_REGS; r++)
      pend[r] = (cnt_q[r] != '0) || (issue && ex_rd == REG_W'(r) && lat_eff != '0);
  end

  // The ecall also waits on a zero-latency writer of its argument register.
  assign hazard = (id_use_rs1 && pend[id_rs1]) ||
                  (id_use_rs2 && pend[id_rs2]) ||
                  (id_is_ecall && (pend[ECALL_REG] ||
                                   (issue && ex_rd == REG_W'(ECALL_REG))));

  // A redirect (re)loads the flush timer; the timer then counts down to idle.
  always_comb begin
    flush_d = '0;
    if (redirect)            flush_d = FC_W'(FLUSH_CYCLES - 1);
    else if (flush_q != '0)  flush_d = flush_q - FC_W'(1);
  end

  assign flushing = redirect || (flush_q != '0);
  // A squashed ID instruction is dead, so it never needs to stall.
  assign stall    = hazard && !flushing;

  // While reset is low, outputs are forced to their free-running values.
  assign control_op  = reset_n && stall;
  assign pc_write    = !control_op;
  assign if_id_write = !control_op;
  assign if_flush    = reset_n && flushing;
  assign id_flush    = reset_n && flushing;

  // Scoreboard and flush timer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, flush_count_q;

  // Saturating per-cycle counts of stall and flush activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (control_op && stall_count_q != '1) stall_count_q <= stall_count_q + 32'd1;
      if (if_flush && flush_count_q != '1)   flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_LAT=5 to exercise latency
// clamping, FLUSH_CYCLES=2 for multi-cycle flushes). Inputs change 1ns after
// the rising edge. Outputs are sampled on the falling edge.
module tb_hazard_scoreboard;
  localparam int REG_W = 5;
  localparam int LAT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, id_is_ecall;
  logic             ex_valid, ex_reg_write, redirect;
  logic [LAT_W-1:0] ex_lat;
  logic             pc_write, if_id_write, control_op, if_flush, id_flush;
  logic [31:0]      stall_count, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard #(.NUM_REGS(32), .REG_W(REG_W), .MAX_LAT(5), .ECALL_REG(17),
                      .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_lat(ex_lat), .redirect(redirect),
    .pc_write(pc_write), .if_id_write(if_id_write), .control_op(control_op),
    .if_flush(if_flush), .id_flush(id_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, control_op, if_flush, id_flush}
  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FLUSH = 5'b11011;

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, control_op, if_flush, id_flush};
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_ecall = 0;
    ex_valid = 0; ex_reg_write = 0; ex_rd = '0; ex_lat = '0; redirect = 0;
  endtask

  task automatic ex_issue(input logic [REG_W-1:0] rd, input logic [LAT_W-1:0] lat);
    ex_valid = 1; ex_reg_write = 1; ex_rd = rd; ex_lat = lat;
  endtask

  task automatic ex_bubble();
    ex_valid = 0; ex_reg_write = 0; ex_rd = '0; ex_lat = '0;
  endtask

  task automatic drain();
    idle();
    repeat (7) next();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    ex_issue(5, 3); id_rs1 = 5; id_use_rs1 = 1; redirect = 1;
    #3;
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected %b", outs(), RUN);
    end
    n_cmp++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
    next(); next();
    idle();
    reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL reset_release_idle: got %b expected %b", outs(), RUN);
    end
    next();
  endtask

  task automatic test_load_use();
    idle();
    ex_issue(5, 1); id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== STALL) begin
      n_bad++; $display("FAIL load_use_c0: got %b expected %b", outs(), STALL);
    end
    next(); ex_bubble();
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL load_use_c1: got %b expected %b", outs(), RUN);
    end
    drain();
  endtask

  task automatic test_multicycle();
    idle();
    ex_issue(7, 3); id_rs2 = 7; id_use_rs2 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (control_op !== (i < 3) || pc_write !== !(i < 3)) begin
        n_bad++; $display("FAIL mul3_cycle%0d: got ctrl=%b pc=%b expected ctrl=%b", i,
                          control_op, pc_write, (i < 3));
      end
      next(); ex_bubble();
    end
    drain();
    // Unrelated source, and rs2 not read.
    ex_issue(7, 3); id_rs1 = 8; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL mul3_unrelated: got %b expected %b", outs(), RUN);
    end
    drain();
    // Latency 7 clamps to MAX_LAT=5.
    ex_issue(3, 7); id_rs1 = 3; id_use_rs1 = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (control_op !== (i < 5)) begin
        n_bad++; $display("FAIL clamp_cycle%0d: got %b expected %b", i, control_op, (i < 5));
      end
      next(); ex_bubble();
    end
    drain();
  endtask

  task automatic test_waw();
    idle();
    ex_issue(9, 5);
    next();
    ex_bubble(); id_rs1 = 9; id_use_rs1 = 1;
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b1) begin
      n_bad++; $display("FAIL waw_mul_pending: got %b expected 1", control_op);
    end
    next();
    ex_issue(9, 1);
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b1) begin
      n_bad++; $display("FAIL waw_load_issue: got %b expected 1", control_op);
    end
    next();
    ex_bubble();
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL waw_youngest_wins: got %b expected %b", outs(), RUN);
    end
    drain();
  endtask

  task automatic test_ecall();
    idle();
    ex_issue(17, 0); id_is_ecall = 1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== STALL) begin
      n_bad++; $display("FAIL ecall_x17_lat0: got %b expected %b", outs(), STALL);
    end
    next(); ex_bubble();
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL ecall_after: got %b expected %b", outs(), RUN);
    end
    next(); ex_issue(10, 0);
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b0) begin
      n_bad++; $display("FAIL ecall_x10: got %b expected 0", control_op);
    end
    next(); ex_issue(0, 3); id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b0) begin
      n_bad++; $display("FAIL ecall_x0: got %b expected 0", control_op);
    end
    next(); id_is_ecall = 0; ex_issue(5, 0); id_rs1 = 5;
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b0) begin
      n_bad++; $display("FAIL lat0_forward: got %b expected 0", control_op);
    end
    next(); id_is_ecall = 1; ex_issue(17, 2); ex_reg_write = 0;
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b0) begin
      n_bad++; $display("FAIL no_reg_write: got %b expected 0", control_op);
    end
    next(); ex_issue(17, 2); ex_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (control_op !== 1'b0) begin
      n_bad++; $display("FAIL bubble_ignored: got %b expected 0", control_op);
    end
    drain();
  endtask

  task automatic test_redirect();
    logic [4:0] exp_seq [9];
    logic       rd_seq  [9];
    exp_seq = '{FLUSH, FLUSH, STALL, STALL, RUN, FLUSH, FLUSH, FLUSH, RUN};
    rd_seq  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0, 1'b1, 1'b1,  1'b0,  1'b0};
    idle();
    ex_issue(5, 4); id_rs1 = 5; id_use_rs1 = 1;
    for (int i = 0; i < 9; i++) begin
      redirect = rd_seq[i];
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp_seq[i]) begin
        n_bad++; $display("FAIL redirect_cycle%0d: got %b expected %b", i, outs(), exp_seq[i]);
      end
      next(); ex_bubble();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    idle();
    ex_issue(7, 4); id_rs1 = 7; id_use_rs1 = 1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== STALL) begin
      n_bad++; $display("FAIL midrst_stall_c0: got %b expected %b", outs(), STALL);
    end
    next(); ex_bubble();
    @(negedge clk);
    n_cmp++;
    if (outs() !== STALL) begin
      n_bad++; $display("FAIL midrst_stall_c1: got %b expected %b", outs(), STALL);
    end
    reset_n = 0; redirect = 1; ex_issue(7, 4);
    #1;
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL midrst_forced: got %b expected %b", outs(), RUN);
    end
    next();
    redirect = 0; ex_bubble();
    reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RUN) begin
      n_bad++; $display("FAIL midrst_cleared: got %b expected %b", outs(), RUN);
    end
    n_cmp++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      n_bad++; $display("FAIL midrst_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
    drain();
  endtask

  task automatic test_perf();
    logic [31:0] exp_s, exp_f, base_s, base_f;
`ifdef HAZARD_PERF_EN
    exp_s = 32'd2; exp_f = 32'd2;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    // Pulse reset so the counters start from zero.
    idle();
    reset_n = 0; #2; reset_n = 1;
    base_s = 0; base_f = 0;
    ex_issue(4, 2); id_rs1 = 4; id_use_rs1 = 1;
    next(); ex_bubble();
    next(); redirect = 1;
    next(); redirect = 0;
    next(); idle();
    @(negedge clk);
    n_cmp++;
    if (stall_count !== base_s + exp_s) begin
      n_bad++; $display("FAIL perf_stall_count: got %0d expected %0d", stall_count, exp_s);
    end
    n_cmp++;
    if (flush_count !== base_f + exp_f) begin
      n_bad++; $display("FAIL perf_flush_count: got %0d expected %0d", flush_count, exp_f);
    end
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_waw();
    test_ecall();
    test_redirect();
    test_reset_mid();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
